// File: rtl/des_sbox_unit.sv
// DES S-box substitution stage: 48-bit key-mixed expansion in, 32-bit pre-P value out.
// LANES S-boxes are evaluated per cycle, so one block takes 8/LANES BUSY cycles.
module des_sbox_unit #(
    parameter int LANES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] din,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] dout,
    output logic        busy
);

    localparam int NCYC = 8 / LANES;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
            $error("des_sbox_unit: LANES must be 1, 2, 4 or 8");
        end
    endgenerate

    // Indexed [box][row*16 + col]; box 0 is S1.
    localparam logic [3:0] SBOX [8][64] = '{
        '{4'd14, 4'd4,  4'd13, 4'd1,  4'd2,  4'd15, 4'd11, 4'd8,  4'd3,  4'd10, 4'd6,  4'd12, 4'd5,  4'd9,  4'd0,  4'd7,
          4'd0,  4'd15, 4'd7,  4'd4,  4'd14, 4'd2,  4'd13, 4'd1,  4'd10, 4'd6,  4'd12, 4'd11, 4'd9,  4'd5,  4'd3,  4'd8,
          4'd4,  4'd1,  4'd14, 4'd8,  4'd13, 4'd6,  4'd2,  4'd11, 4'd15, 4'd12, 4'd9,  4'd7,  4'd3,  4'd10, 4'd5,  4'd0,
          4'd15, 4'd12, 4'd8,  4'd2,  4'd4,  4'd9,  4'd1,  4'd7,  4'd5,  4'd11, 4'd3,  4'd14, 4'd10, 4'd0,  4'd6,  4'd13},
        '{4'd15, 4'd1,  4'd8,  4'd14, 4'd6,  4'd11, 4'd3,  4'd4,  4'd9,  4'd7,  4'd2,  4'd13, 4'd12, 4'd0,  4'd5,  4'd10,
          4'd3,  4'd13, 4'd4,  4'd7,  4'd15, 4'd2,  4'd8,  4'd14, 4'd12, 4'd0,  4'd1,  4'd10, 4'd6,  4'd9,  4'd11, 4'd5,
          4'd0,  4'd14, 4'd7,  4'd11, 4'd10, 4'd4,  4'd13, 4'd1,  4'd5,  4'd8,  4'd12, 4'd6,  4'd9,  4'd3,  4'd2,  4'd15,
          4'd13, 4'd8,  4'd10, 4'd1,  4'd3,  4'd15, 4'd4,  4'd2,  4'd11, 4'd6,  4'd7,  4'd12, 4'd0,  4'd5,  4'd14, 4'd9},
        '{4'd10, 4'd0,  4'd9,  4'd14, 4'd6,  4'd3,  4'd15, 4'd5,  4'd1,  4'd13, 4'd12, 4'd7,  4'd11, 4'd4,  4'd2,  4'd8,
          4'd13, 4'd7,  4'd0,  4'd9,  4'd3,  4'd4,  4'd6,  4'd10, 4'd2,  4'd8,  4'd5,  4'd14, 4'd12, 4'd11, 4'd15, 4'd1,
          4'd13, 4'd6,  4'd4,  4'd9,  4'd8,  4'd15, 4'd3,  4'd0,  4'd11, 4'd1,  4'd2,  4'd12, 4'd5,  4'd10, 4'd14, 4'd7,
          4'd1,  4'd10, 4'd13, 4'd0,  4'd6,  4'd9,  4'd8,  4'd7,  4'd4,  4'd15, 4'd14, 4'd3,  4'd11, 4'd5,  4'd2,  4'd12},
        '{4'd7,  4'd13, 4'd14, 4'd3,  4'd0,  4'd6,  4'd9,  4'd10, 4'd1,  4'd2,  4'd8,  4'd5,  4'd11, 4'd12, 4'd4,  4'd15,
          4'd13, 4'd8,  4'd11, 4'd5,  4'd6,  4'd15, 4'd0,  4'd3,  4'd4,  4'd7,  4'd2,  4'd12, 4'd1,  4'd10, 4'd14, 4'd9,
          4'd10, 4'd6,  4'd9,  4'd0,  4'd12, 4'd11, 4'd7,  4'd13, 4'd15, 4'd1,  4'd3,  4'd14, 4'd5,  4'd2,  4'd8,  4'd4,
          4'd3,  4'd15, 4'd0,  4'd6,  4'd10, 4'd1,  4'd13, 4'd8,  4'd9,  4'd4,  4'd5,  4'd11, 4'd12, 4'd7,  4'd2,  4'd14},
        '{4'd2,  4'd12, 4'd4,  4'd1,  4'd7,  4'd10, 4'd11, 4'd6,  4'd8,  4'd5,  4'd3,  4'd15, 4'd13, 4'd0,  4'd14, 4'd9,
          4'd14, 4'd11, 4'd2,  4'd12, 4'd4,  4'd7,  4'd13, 4'd1,  4'd5,  4'd0,  4'd15, 4'd10, 4'd3,  4'd9,  4'd8,  4'd6,
          4'd4,  4'd2,  4'd1,  4'd11, 4'd10, 4'd13, 4'd7,  4'd8,  4'd15, 4'd9,  4'd12, 4'd5,  4'd6,  4'd3,  4'd0,  4'd14,
          4'd11, 4'd8,  4'd12, 4'd7,  4'd1,  4'd14, 4'd2,  4'd13, 4'd6,  4'd15, 4'd0,  4'd9,  4'd10, 4'd4,  4'd5,  4'd3},
        '{4'd12, 4'd1,  4'd10, 4'd15, 4'd9,  4'd2,  4'd6,  4'd8,  4'd0,  4'd13, 4'd3,  4'd4,  4'd14, 4'd7,  4'd5,  4'd11,
          4'd10, 4'd15, 4'd4,  4'd2,  4'd7,  4'd12, 4'd9,  4'd5,  4'd6,  4'd1,  4'd13, 4'd14, 4'd0,  4'd11, 4'd3,  4'd8,
          4'd9,  4'd14, 4'd15, 4'd5,  4'd2,  4'd8,  4'd12, 4'd3,  4'd7,  4'd0,  4'd4,  4'd10, 4'd1,  4'd13, 4'd11, 4'd6,
          4'd4,  4'd3,  4'd2,  4'd12, 4'd9,  4'd5,  4'd15, 4'd10, 4'd11, 4'd14, 4'd1,  4'd7,  4'd6,  4'd0,  4'd8,  4'd13},
        '{4'd4,  4'd11, 4'd2,  4'd14, 4'd15, 4'd0,  4'd8,  4'd13, 4'd3,  4'd12, 4'd9,  4'd7,  4'd5,  4'd10, 4'd6,  4'd1,
          4'd13, 4'd0,  4'd11, 4'd7,  4'd4,  4'd9,  4'd1,  4'd10, 4'd14, 4'd3,  4'd5,  4'd12, 4'd2,  4'd15, 4'd8,  4'd6,
          4'd1,  4'd4,  4'd11, 4'd13, 4'd12, 4'd3,  4'd7,  4'd14, 4'd10, 4'd15, 4'd6,  4'd8,  4'd0,  4'd5,  4'd9,  4'd2,
          4'd6,  4'd11, 4'd13, 4'd8,  4'd1,  4'd4,  4'd10, 4'd7,  4'd9,  4'd5,  4'd0,  4'd15, 4'd14, 4'd2,  4'd3,  4'd12},
        '{4'd13, 4'd2,  4'd8,  4'd4,  4'd6,  4'd15, 4'd11, 4'd1,  4'd10, 4'd9,  4'd3,  4'd14, 4'd5,  4'd0,  4'd12, 4'd7,
          4'd1,  4'd15, 4'd13, 4'd8,  4'd10, 4'd3,  4'd7,  4'd4,  4'd12, 4'd5,  4'd6,  4'd11, 4'd0,  4'd14, 4'd9,  4'd2,
          4'd7,  4'd11, 4'd4,  4'd1,  4'd9,  4'd12, 4'd14, 4'd2,  4'd0,  4'd6,  4'd10, 4'd13, 4'd15, 4'd3,  4'd5,  4'd8,
          4'd2,  4'd1,  4'd14, 4'd7,  4'd4,  4'd10, 4'd8,  4'd13, 4'd15, 4'd12, 4'd9,  4'd0,  4'd3,  4'd5,  4'd6,  4'd11}
    };

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [0:7][5:0] din_q;     // element 0 is the S1 chunk (din[47:42])
    logic [0:7][3:0] res_q;     // element 0 is the S1 nibble (dout[31:28])
    logic [0:7][3:0] res_next;
    logic [CW-1:0]   cnt;
    logic            accept;

    logic [2:0] lane_box [LANES];
    logic [3:0] lane_nib [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [5:0] chunk;
        assign lane_box[l] = 3'(int'(cnt) * LANES + l);
        assign chunk       = din_q[lane_box[l]];
        assign lane_nib[l] = SBOX[lane_box[l]][{chunk[5], chunk[0], chunk[4:1]}];
    end

    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        res_next = res_q;
        for (int l = 0; l < LANES; l++) begin
            res_next[lane_box[l]] = lane_nib[l];
        end
    end

    assign in_ready  = !rst && ((state == IDLE) || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign busy      = (state == BUSY);
    assign out_valid = (state == DONE);
    assign dout      = out_valid ? res_q : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            din_q <= '0;
            res_q <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        din_q <= din;
                        res_q <= '0;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    res_q <= res_next;
                    if (cnt == CW'(NCYC - 1)) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    // Output handshake and next-block accept can share one edge.
                    if (out_ready) begin
                        if (accept) begin
                            din_q <= din;
                            res_q <= '0;
                            cnt   <= '0;
                            state <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_sbox_unit.sv
// Bench for des_sbox_unit: four instances (LANES 1,2,4,8), directed vectors, backpressure,
// mid-block reset and a random scoreboard run against an independent S-box model.
module tb_des_sbox_unit;

    // Each row packs 16 nibbles, column 0 in the top nibble; entry index is box*4 + row.
    localparam logic [63:0] TB_TAB [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    typedef struct {
        int          k;
        logic [47:0] din;
        logic [31:0] exp;
        string       tag;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid_a  [4];
    logic        in_ready_a  [4];
    logic [47:0] din_a       [4];
    logic        out_valid_a [4];
    logic        out_ready_a [4];
    logic [31:0] dout_a      [4];
    logic        busy_a      [4];

    logic [31:0] sb_q [4][$];
    int          checks;
    int          errors;
    bit          rnd_run;
    int          rnd_done;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        des_sbox_unit #(.LANES(1 << g)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid_a[g]),
            .in_ready (in_ready_a[g]),
            .din      (din_a[g]),
            .out_valid(out_valid_a[g]),
            .out_ready(out_ready_a[g]),
            .dout     (dout_a[g]),
            .busy     (busy_a[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: time budget exceeded");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [47:0] d);
        logic [31:0] r;
        logic [5:0]  c;
        logic [63:0] row;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            c   = d[47 - 6*b -: 6];
            row = TB_TAB[b*4 + int'({c[5], c[0]})];
            r[31 - 4*b -: 4] = row[63 - 4*int'(c[4:1]) -: 4];
        end
        return r;
    endfunction

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                sb_q[k].delete();
            end else begin
                if (out_valid_a[k] === 1'b0) check("dout_masked", dout_a[k], 0);
                if (out_valid_a[k] && out_ready_a[k]) begin
                    check("sb_expected_pending", sb_q[k].size() != 0, 1);
                    if (sb_q[k].size() != 0) check("sb_dout", dout_a[k], sb_q[k].pop_front());
                end
                if (in_valid_a[k] && in_ready_a[k]) sb_q[k].push_back(model(din_a[k]));
            end
        end
    end

    task automatic run_vec(input int k, input logic [47:0] d, input logic [31:0] exp, input string tag);
        int  busy_n;
        int  n;
        bit  seen;
        out_ready_a[k] = 1'b1;
        in_valid_a[k]  = 1'b1;
        din_a[k]       = d;
        @(negedge clk);
        check({tag, "_in_ready_idle"}, in_ready_a[k], 1);
        @(posedge clk); #1;
        in_valid_a[k] = 1'b0;
        busy_n = 0;
        seen   = 1'b0;
        n      = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (out_valid_a[k]) begin
                seen = 1'b1;
            end else begin
                if (busy_a[k]) busy_n++;
                check({tag, "_in_ready_busy"}, in_ready_a[k], 0);
            end
        end
        check({tag, "_out_valid"}, seen, 1);
        check({tag, "_latency"}, n - 1, 8 >> k);
        check({tag, "_busy_cycles"}, busy_n, 8 >> k);
        check({tag, "_dout"}, dout_a[k], exp);
        @(posedge clk); #1;
    endtask

    task automatic rand_feed(input int k);
        bit acc;
        int t;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            in_valid_a[k] = 1'b1;
            din_a[k]      = 48'({$urandom(), $urandom()});
            acc = 1'b0;
            t   = 0;
            while (!acc && t < 300) begin
                @(negedge clk);
                acc = in_ready_a[k];
                @(posedge clk); #1;
                t++;
            end
            in_valid_a[k] = 1'b0;
            check("rnd_accept", acc, 1);
        end
    endtask

    task automatic rand_ready(input int k);
        while (rnd_run) begin
            @(posedge clk); #1;
            out_ready_a[k] = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        vec_t vecs[6];
        int   n;
        int   pulses;

        checks  = 0;
        errors  = 0;
        rnd_run = 1'b0;
        rst     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid_a[k]  = 1'b0;
            din_a[k]       = '0;
            out_ready_a[k] = 1'b1;
        end

        // Reset state
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("rst_in_ready", in_ready_a[k], 0);
            check("rst_out_valid", out_valid_a[k], 0);
            check("rst_busy", busy_a[k], 0);
            check("rst_dout", dout_a[k], 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) check("idle_in_ready", in_ready_a[k], 1);
        @(posedge clk); #1;

        // Directed vectors; k selects LANES = 1 << k
        vecs[0] = '{k: 3, din: 48'h000000000000, exp: 32'hEFA72C4D, tag: "l8_zero"};
        vecs[1] = '{k: 3, din: 48'hFFFFFFFFFFFF, exp: 32'hD9CE3DCB, tag: "l8_ones"};
        vecs[2] = '{k: 3, din: 48'h6117BA866527, exp: 32'h5C82B597, tag: "l8_ref"};
        vecs[3] = '{k: 0, din: 48'h6117BA866527, exp: 32'h5C82B597, tag: "l1_ref"};
        vecs[4] = '{k: 1, din: 48'h6117BA866527, exp: 32'h5C82B597, tag: "l2_ref"};
        vecs[5] = '{k: 2, din: 48'hFFFFFFFFFFFF, exp: 32'hD9CE3DCB, tag: "l4_ones"};
        for (int i = 0; i < 6; i++) run_vec(vecs[i].k, vecs[i].din, vecs[i].exp, vecs[i].tag);

        // Backpressure on LANES=4, then same-cycle handoff to the next block
        out_ready_a[2] = 1'b0;
        in_valid_a[2]  = 1'b1;
        din_a[2]       = '0;
        @(posedge clk); #1;
        in_valid_a[2] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid_a[2] && n < 20);
        check("bp_out_valid", out_valid_a[2], 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_dout_held", dout_a[2], 32'hEFA72C4D);
            check("bp_in_ready_low", in_ready_a[2], 0);
            check("bp_valid_held", out_valid_a[2], 1);
        end
        @(posedge clk); #1;
        out_ready_a[2] = 1'b1;
        in_valid_a[2]  = 1'b1;
        din_a[2]       = 48'hFFFFFFFFFFFF;
        @(negedge clk);
        check("bp_same_cycle_ready", in_ready_a[2], 1);
        check("bp_dout_before_release", dout_a[2], 32'hEFA72C4D);
        @(posedge clk); #1;
        in_valid_a[2] = 1'b0;
        @(negedge clk);
        check("bp_next_busy1", out_valid_a[2], 0);
        @(negedge clk);
        check("bp_next_busy2", out_valid_a[2], 0);
        @(negedge clk);
        check("bp_next_valid", out_valid_a[2], 1);
        check("bp_next_dout", dout_a[2], 32'hD9CE3DCB);
        @(posedge clk); #1;

        // Reset during the third BUSY cycle of a LANES=1 block
        in_valid_a[0] = 1'b1;
        din_a[0]      = 48'h6117BA866527;
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstmid_busy_before", busy_a[0], 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_in_ready_in_rst", in_ready_a[0], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_busy", busy_a[0], 0);
        check("rstmid_out_valid", out_valid_a[0], 0);
        check("rstmid_dout", dout_a[0], 0);
        check("rstmid_in_ready", in_ready_a[0], 1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid_a[0]) pulses++;
        end
        check("rstmid_no_pulse", pulses, 0);
        @(posedge clk); #1;
        run_vec(0, 48'h000000000000, 32'hEFA72C4D, "rstmid_fresh");

        // Random regression on all four lane counts at once
        rnd_run  = 1'b1;
        rnd_done = 0;
        for (int k = 0; k < 4; k++) begin
            fork
                automatic int kk = k;
                begin
                    rand_feed(kk);
                    rnd_done++;
                end
                rand_ready(kk);
            join_none
        end
        n = 0;
        while (rnd_done < 4 && n < 50000) begin
            @(posedge clk);
            n++;
        end
        check("rnd_feeders_done", rnd_done, 4);
        n = 0;
        while ((sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size()) != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        rnd_run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            out_ready_a[k] = 1'b1;
            check("rnd_drained", sb_q[k].size(), 0);
        end
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/des_sbox_unit.md
Name: des_sbox_unit

Overview:
- Complete DES S-box substitution stage: maps the 48-bit key-mixed expansion output to the 32-bit pre-permutation round value using all eight DES S-boxes.
- Sits between the E-expansion/key-XOR and the P-permutation in the round datapath.
- Parametrised lane count trades area for latency: 8 lookups per cycle (fully parallel) down to 1 per cycle (serial).
- Valid/ready handshakes on both sides; the S-box tables are fixed constants inside the block, with no file-loaded memory.

Parameters:
- LANES, 8, S-boxes evaluated per cycle. Legal values are 1, 2, 4, 8; anything else is an elaboration error.
- NCYC, 8/LANES (derived, not overridable), number of BUSY cycles per block.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  din valid
- in_ready  output  1  block can accept din
- din  input  48  S-box input; din[47:42] feeds S1 … din[5:0] feeds S8
- out_valid  output  1  dout valid
- out_ready  input  1  downstream accepts dout
- dout  output  32  substitution result; dout[31:28] from S1 … dout[3:0] from S8
- busy  output  1  high in BUSY state

Behaviour:
- Reset: sampled on clk edge while rst=1. State goes to IDLE; dout, the result register, the input latch and the lane counter are all cleared to 0; out_valid=0, busy=0.
- in_ready is 0 in any cycle where rst=1.
- Chunk decode, per 6-bit chunk c[5:0] with c[5] the DES MSB: row = {c[5],c[0]}, col = c[4:1]. Table index = row*16 + col, standard FIPS 46-3 S1..S8 tables.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch din, clear the result register, set cnt=0, go to BUSY.
- BUSY:
  - in_ready=0, busy=1.
  - Each cycle: look up S-boxes cnt*LANES+1 … (cnt+1)*LANES from the latched input, write those nibbles into the result register, then increment cnt.
  - When cnt=NCYC-1, go to DONE.
- DONE:
  - out_valid=1; dout = result register, held stable until out_valid&out_ready.
  - On that handshake: if in_valid is also high, accept the new din in the same cycle and go to BUSY; otherwise go to IDLE.
  - in_ready = out_ready (combinational) in DONE.
  - Without out_ready, remain in DONE indefinitely with dout unchanged.
- Latency: the accept edge is cycle 0; out_valid rises after NCYC edges. LANES=8 gives 1 cycle; LANES=1 gives 8 cycles.
- Throughput: one block per NCYC+1 cycles with continuous in_valid and out_ready.
- dout is 0 whenever out_valid=0 (masked, not merely stale).
- in_valid while in_ready=0 is ignored; upstream must hold din and in_valid until in_ready.
- Reset mid-BUSY or mid-DONE: the block is discarded, no out_valid pulse follows, and the IDLE conditions above apply on the next cycle.
- cnt width is max(1, log2(NCYC)). It must never exceed NCYC-1; no wrap beyond it.
- Tables are pure combinational constants; the lane multiplexers select 6-bit chunks by cnt. No combinational path from din to dout.

Test Plan:
- LANES=8, din=0x000000000000, out_ready=1 -> out_valid one cycle after accept, dout=0xEFA72C4D.
- LANES=8, din=0xFFFFFFFFFFFF -> dout=0xD9CE3DCB. Then din=0x6117BA866527 -> dout=0x5C82B597.
- LANES=1 and LANES=2, din=0x6117BA866527 -> busy high 8 and 4 cycles respectively; out_valid after 8 and 4 cycles; dout=0x5C82B597. in_ready=0 throughout BUSY.
- Backpressure: LANES=4, out_ready=0 for 5 cycles after out_valid -> dout held at 0xEFA72C4D and in_ready=0. Then out_ready=1 with in_valid=1, din=all-ones -> same-cycle accept; next result 0xD9CE3DCB after 2 cycles.
- Reset mid-operation: LANES=1, assert rst at BUSY cycle 3 -> next cycle state IDLE, dout=0, out_valid never pulses. A fresh block then returns its correct value.
- Random regression: 1000 random din values at all four LANES settings, random out_ready -> dout matches the software DES S-box model. Every accepted input yields exactly one output, in order.
